// File: rtl/uart_loader_pkg.sv
// Shared constants, state encodings and helpers for the UART program loader.
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;
  localparam logic [7:0] CMD_READ  = 8'h04;
  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CSUM, ST_EXEC,
    ST_DRAIN, ST_RDWAIT, ST_RDCAP, ST_RESP
  } state_t;

  typedef enum logic [1:0] {HS_IDLE, HS_START, HS_WAIT} hs_state_t;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/loader_tx_handshake.sv
// Transmitter front end: holds tx_start until tx_busy rises, then waits for
// tx_busy to fall before reporting the byte as done.
module loader_tx_handshake
  import uart_loader_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       done_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_busy_i
);

  hs_state_t  hsState_q, hsState_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hsState_q <= HS_IDLE;
      data_q    <= 8'd0;
    end else begin
      hsState_q <= hsState_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    hsState_d = hsState_q;
    data_d    = data_q;
    done_o    = 1'b0;
    case (hsState_q)
      HS_IDLE: begin
        if (valid_i) begin
          data_d    = byte_i;
          hsState_d = HS_START;
        end
      end
      HS_START: if (tx_busy_i) hsState_d = HS_WAIT;
      HS_WAIT: begin
        if (!tx_busy_i) begin
          done_o    = 1'b1;
          hsState_d = HS_IDLE;
        end
      end
      default: hsState_d = HS_IDLE;
    endcase
  end

  assign tx_start_o = (hsState_q == HS_START);
  assign tx_data_o  = data_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Packet parser that loads instruction memory over UART and gates CPU reset.
// Define LOADER_READBACK_EN to enable the READ (04) command.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              cpu_reset_o,
  output logic              loading_o,
  output logic [7:0]        err_count_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               rxPrev_q;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [7:0]         cmd_q, cmd_d, csum_q, csum_d;
  logic [15:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               cpuReset_q, cpuReset_d;
  logic [7:0]         errCount_q, errCount_d;
  logic               memWe_q, memWe_d, memRe_q, memRe_d;
  logic [ADDR_W-1:0]  memAddr_q, memAddr_d;
  logic [31:0]        memWdata_q, memWdata_d;
  logic [39:0]        respBuf_q, respBuf_d;
  logic [2:0]         respLeft_q, respLeft_d;
  logic               sent_q, sent_d;
  logic               byteEdge, timerActive, timeout, addrOk, hsValid, hsDone;

  assign byteEdge    = rx_ready_i && !rxPrev_q;
  assign timerActive = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CSUM, ST_DRAIN};
  assign timeout     = timerActive && !byteEdge && (timer_q == TIMER_MAX);
  assign addrOk      = (({16'd0, addr_q} >> ADDR_W) == 32'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      rxPrev_q   <= 1'b0;
      timer_q    <= '0;
      cnt_q      <= 2'd0;
      cmd_q      <= 8'd0;
      csum_q     <= 8'd0;
      addr_q     <= 16'd0;
      data_q     <= 32'd0;
      cpuReset_q <= 1'b1;
      errCount_q <= 8'd0;
      memWe_q    <= 1'b0;
      memRe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= 32'd0;
      respBuf_q  <= 40'd0;
      respLeft_q <= 3'd0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxPrev_q   <= rx_ready_i;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cpuReset_q <= cpuReset_d;
      errCount_q <= errCount_d;
      memWe_q    <= memWe_d;
      memRe_q    <= memRe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      respBuf_q  <= respBuf_d;
      respLeft_q <= respLeft_d;
      sent_q     <= sent_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = (timerActive && !byteEdge) ? timer_q + TW'(1) : '0;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cpuReset_d = cpuReset_q;
    errCount_d = errCount_q;
    memWe_d    = 1'b0;
    memRe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    respBuf_d  = respBuf_q;
    respLeft_d = respLeft_q;
    sent_d     = sent_q;
    hsValid    = 1'b0;
    case (state_q)
      ST_IDLE: if (byteEdge && rx_data_i == SYNC_BYTE) state_d = ST_CMD;
      ST_CMD: begin
        if (byteEdge) begin
          cmd_d  = rx_data_i;
          csum_d = rx_data_i;
          addr_d = 16'd0;
          cnt_d  = 2'd0;
          case (rx_data_i)
            CMD_WRITE: state_d = ST_ADDR;
`ifdef LOADER_READBACK_EN
            CMD_READ:  state_d = ST_ADDR;
`endif
            CMD_RUN, CMD_HALT: state_d = ST_CSUM;
            default:   state_d = ST_DRAIN;
          endcase
        end
      end
      ST_ADDR: begin
        if (byteEdge) begin
          addr_d = {rx_data_i, addr_q[15:8]};
          csum_d = csum_q ^ rx_data_i;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = (cmd_q == CMD_WRITE) ? ST_DATA : ST_CSUM;
          end
        end
      end
      ST_DATA: begin
        if (byteEdge) begin
          data_d = {rx_data_i, data_q[31:8]};
          csum_d = csum_q ^ rx_data_i;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byteEdge) begin
          csum_d  = csum_q ^ rx_data_i;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        sent_d     = 1'b0;
        respLeft_d = 3'd1;
        state_d    = ST_RESP;
        if (csum_q != 8'd0 || !addrOk) begin
          respBuf_d  = {32'd0, RESP_NAK};
          errCount_d = satInc(errCount_q);
        end else begin
          respBuf_d = {32'd0, RESP_ACK};
          case (cmd_q)
            CMD_WRITE: begin
              memWe_d    = 1'b1;
              memAddr_d  = addr_q[ADDR_W-1:0];
              memWdata_d = data_q;
            end
            CMD_RUN:  cpuReset_d = 1'b0;
            CMD_HALT: cpuReset_d = 1'b1;
`ifdef LOADER_READBACK_EN
            CMD_READ: begin
              memRe_d   = 1'b1;
              memAddr_d = addr_q[ADDR_W-1:0];
              state_d   = ST_RDWAIT;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RDWAIT: state_d = ST_RDCAP;
      ST_RDCAP: begin
        respBuf_d  = {mem_rdata_i, RESP_ACK};
        respLeft_d = 3'd5;
        sent_d     = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        hsValid = !sent_q;
        if (hsValid) sent_d = 1'b1;
        if (hsDone) begin
          sent_d     = 1'b0;
          respBuf_d  = respBuf_q >> 8;
          respLeft_d = respLeft_q - 3'd1;
          if (respLeft_q == 3'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    // An unknown command has no length, so DRAIN answers only when the line goes quiet.
    if (timeout) begin
      errCount_d = satInc(errCount_q);
      if (state_q == ST_DRAIN) begin
        respBuf_d  = {32'd0, RESP_NAK};
        respLeft_d = 3'd1;
        sent_d     = 1'b0;
        state_d    = ST_RESP;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  loader_tx_handshake uTxHs (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .byte_i     (respBuf_q[7:0]),
    .valid_i    (hsValid),
    .done_o     (hsDone),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_busy_i  (tx_busy_i)
  );

`ifndef LOADER_READBACK_EN
  logic unusedRdata;
  assign unusedRdata = ^mem_rdata_i;
`endif

  assign mem_we_o    = memWe_q;
  assign mem_re_o    = memRe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign cpu_reset_o = cpuReset_q;
  assign loading_o   = (state_q != ST_IDLE);
  assign err_count_o = errCount_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected tx bytes and memory writes are
// queued by the stimulus and retired by independent monitors.
module tb_uart_prog_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rxData;
  logic              rxReady;
  logic              txStart;
  logic [7:0]        txData;
  logic              txBusy;
  logic              memWe, memRe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [31:0]       memRdata = 32'd0;
  logic              cpuReset, loading;
  logic [7:0]        errCount;

  int checks = 0;
  int passes = 0;
  logic [7:0]        txExp[$];
  logic [ADDR_W+31:0] wrExp[$];
  logic [31:0]       memModel [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_data_i   (rxData),
    .rx_ready_i  (rxReady),
    .tx_start_o  (txStart),
    .tx_data_o   (txData),
    .tx_busy_i   (txBusy),
    .mem_we_o    (memWe),
    .mem_re_o    (memRe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata),
    .cpu_reset_o (cpuReset),
    .loading_o   (loading),
    .err_count_o (errCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (memWe) memModel[memAddr] <= memWdata;
    if (memRe) memRdata <= memModel[memAddr];
  end

  // Write monitor: every strobe cycle must match the next queued write.
  always @(negedge clk) begin
    if (reset === 1'b0 && memWe === 1'b1) begin
      if (wrExp.size() == 0) begin
        checkOutput("unexpectedWrite", {22'd0, memAddr}, 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+31:0] e;
        e = wrExp.pop_front();
        checkOutput("memAddr", {22'd0, memAddr}, {22'd0, e[ADDR_W+31:32]});
        checkOutput("memWdata", memWdata, e[31:0]);
      end
    end
  end

  // Transmitter model: delayed baud-tick start sampling, then a busy window.
  logic       held, stable;
  logic [7:0] cap;
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart === 1'b1 && reset === 1'b0) begin
        held = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (txStart !== 1'b1) held = 1'b0;
        end
        txBusy = 1'b1;
        cap = txData;
        if (txExp.size() == 0) checkOutput("unexpectedTx", {24'd0, cap}, 32'hFFFF_FFFF);
        else checkOutput("txByte", {24'd0, cap}, {24'd0, txExp.pop_front()});
        checkOutput("txStartHeld", {31'd0, held}, 32'd1);
        stable = 1'b1;
        repeat (8) begin
          @(negedge clk);
          if (txData !== cap) stable = 1'b0;
        end
        checkOutput("txDataStable", {31'd0, stable}, 32'd1);
        checkOutput("txStartDropped", {31'd0, txStart}, 32'd0);
        txBusy = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int hold);
    @(negedge clk);
    rxData  = b;
    rxReady = 1'b1;
    repeat (hold) @(negedge clk);
    rxReady = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendPkt(input logic [71:0] v, input int n, input int hold);
    for (int i = 0; i < n; i++) applyStimulus(v[71-8*i -: 8], hold);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (loading === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("returnedIdle", {31'd0, loading}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    rxData  = 8'd0;
    rxReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstCpuReset", {31'd0, cpuReset}, 32'd1);
    checkOutput("rstLoading", {31'd0, loading}, 32'd0);
    checkOutput("rstErrCount", {24'd0, errCount}, 32'd0);
    checkOutput("rstTxStart", {31'd0, txStart}, 32'd0);
    checkOutput("rstTxData", {24'd0, txData}, 32'd0);
    checkOutput("rstMemWe", {31'd0, memWe}, 32'd0);
    checkOutput("rstMemRe", {31'd0, memRe}, 32'd0);
    checkOutput("rstMemAddr", {22'd0, memAddr}, 32'd0);
    checkOutput("rstMemWdata", memWdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(8'h00, 1);
    applyStimulus(8'h55, 1);
    checkOutput("noiseIgnored", {31'd0, loading}, 32'd0);

    wrExp.push_back({10'h010, 32'hDEADBEEF});
    txExp.push_back(8'h06);
    sendPkt({8'hA5, 8'h01, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33}, 9, 1);
    waitIdle(1000);
    checkOutput("errAfterWrite", {24'd0, errCount}, 32'd0);

    txExp.push_back(8'h15);
    sendPkt({8'hA5, 8'h01, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34}, 9, 1);
    waitIdle(1000);
    checkOutput("errAfterBadCsum", {24'd0, errCount}, 32'd1);

    txExp.push_back(8'h06);
    sendPkt({8'hA5, 8'h02, 8'h02, 48'h0}, 3, 1);
    waitIdle(1000);
    checkOutput("cpuResetRun", {31'd0, cpuReset}, 32'd0);
    txExp.push_back(8'h06);
    sendPkt({8'hA5, 8'h03, 8'h03, 48'h0}, 3, 1);
    waitIdle(1000);
    checkOutput("cpuResetHalt", {31'd0, cpuReset}, 32'd1);

    sendPkt({8'hA5, 8'h01, 8'h10, 48'h0}, 3, 1);
    checkOutput("loadingMidPacket", {31'd0, loading}, 32'd1);
    waitIdle(2000);
    checkOutput("errAfterTimeout", {24'd0, errCount}, 32'd2);
    wrExp.push_back({10'h011, 32'h12345678});
    txExp.push_back(8'h06);
    sendPkt({8'hA5, 8'h01, 8'h11, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h18}, 9, 1);
    waitIdle(1000);
    checkOutput("errAfterRecovery", {24'd0, errCount}, 32'd2);

    txExp.push_back(8'h15);
    sendPkt({8'hA5, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41}, 9, 20);
    waitIdle(1000);
    checkOutput("errAfterRange", {24'd0, errCount}, 32'd3);
    txExp.push_back(8'h06);
    sendPkt({8'hA5, 8'h02, 8'h02, 48'h0}, 3, 20);
    waitIdle(1000);
    checkOutput("cpuResetRunHeld", {31'd0, cpuReset}, 32'd0);

    txExp.push_back(8'h15);
    sendPkt({8'hA5, 8'h07, 56'h0}, 2, 1);
    waitIdle(2000);
    checkOutput("errAfterDrain", {24'd0, errCount}, 32'd4);

`ifdef LOADER_READBACK_EN
    txExp.push_back(8'h06);
    txExp.push_back(8'hEF);
    txExp.push_back(8'hBE);
    txExp.push_back(8'hAD);
    txExp.push_back(8'hDE);
    sendPkt({8'hA5, 8'h04, 8'h10, 8'h00, 8'h14, 32'h0}, 5, 1);
    waitIdle(2000);
    checkOutput("errAfterRead", {24'd0, errCount}, 32'd4);
`else
    txExp.push_back(8'h15);
    sendPkt({8'hA5, 8'h04, 8'h10, 8'h00, 8'h14, 32'h0}, 5, 1);
    waitIdle(2000);
    checkOutput("errAfterRead", {24'd0, errCount}, 32'd5);
`endif

    for (int i = 0; i < 260; i++) begin
      txExp.push_back(8'h15);
      sendPkt({8'hA5, 8'h02, 8'h03, 48'h0}, 3, 1);
      waitIdle(1000);
    end
    checkOutput("errSaturated", {24'd0, errCount}, 32'd255);
    checkOutput("cpuResetAfterNaks", {31'd0, cpuReset}, 32'd0);

    sendPkt({8'hA5, 8'h01, 8'h12, 8'h00, 8'hAA, 32'h0}, 5, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstLoading", {31'd0, loading}, 32'd0);
    checkOutput("midRstCpuReset", {31'd0, cpuReset}, 32'd1);
    checkOutput("midRstErrCount", {24'd0, errCount}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midRstStaysIdle", {31'd0, loading}, 32'd0);
    txExp.push_back(8'h06);
    sendPkt({8'hA5, 8'h02, 8'h02, 48'h0}, 3, 1);
    waitIdle(1000);
    checkOutput("runAfterRst", {31'd0, cpuReset}, 32'd0);

    repeat (20) @(negedge clk);
    checkOutput("txQueueDrained", txExp.size(), 32'd0);
    checkOutput("wrQueueDrained", wrExp.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
